// File: rtl/dusterthefirst_pkg.sv
// Shared types and constants for the Manchester frame receiver.
package dusterthefirst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam int ADDR_BITS = 4;
  localparam int DATA_BITS = 8;
  localparam logic [ADDR_BITS-1:0] BROADCAST_ADDR = 4'hF;

  // A frame is for us when it carries our node address or the broadcast address.
  function automatic logic addr_match(input logic [ADDR_BITS-1:0] frame_addr,
                                      input logic [ADDR_BITS-1:0] node_addr);
    return (frame_addr == node_addr) || (frame_addr == BROADCAST_ADDR);
  endfunction

endpackage

// File: rtl/dusterthefirst_project_rx.sv
// Manchester line front end: input/halt synchronisers, edge detection and
// mid-bit timing. Produces one bit_strobe per decoded bit plus a timeout flag.
module manchester_rx
  import dusterthefirst_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int IDLE_BITS    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  input  logic i_halt,
  input  logic i_idle,
  input  logic i_clear,
  output logic o_halt,
  output logic o_pos_edge,
  output logic o_neg_edge,
  output logic o_bit_strobe,
  output logic o_bit_val,
  output logic o_timeout
);

  localparam int CNT_MAX = IDLE_BITS * CLKS_PER_BIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int THRESH  = (3 * CLKS_PER_BIT) / 4;
  localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] THRESH_V  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             r_line1;
  logic             r_line2;
  logic             r_prev;
  logic             r_halt1;
  logic             r_halt2;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pos;
  logic             w_neg;
  logic             w_mid;
  logic             w_strobe;

  // Two-flop synchronisers for line and halt, plus the previous-sample flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line1 <= 1'b0;
      r_line2 <= 1'b0;
      r_prev  <= 1'b0;
      r_halt1 <= 1'b0;
      r_halt2 <= 1'b0;
    end else begin
      r_line1 <= i_line;
      r_line2 <= r_line1;
      r_prev  <= r_line2;
      r_halt1 <= i_halt;
      r_halt2 <= r_halt1;
    end
  end

  assign w_pos    = r_line2 & ~r_prev;
  assign w_neg    = ~r_line2 & r_prev;
  // Edges arriving early in the bit period are boundary transitions, not data.
  assign w_mid    = (w_pos | w_neg) && (r_cnt >= THRESH_V);
  assign w_strobe = w_mid & ~r_halt2 & ~i_idle;

  // Next value of the bit-period counter: frozen in halt, cleared on frame start or data edge.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_halt2) begin
      w_cnt_nxt = r_cnt;
    end else if (i_clear || w_strobe) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != CNT_MAX_V) begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Bit-period counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_halt       = r_halt2;
  assign o_pos_edge   = w_pos;
  assign o_neg_edge   = w_neg;
  assign o_bit_strobe = w_strobe;
  assign o_bit_val    = w_pos;
  assign o_timeout    = (r_cnt == CNT_MAX_V) & ~r_halt2;

endmodule

// File: rtl/dusterthefirst_project.sv
// Tiny Tapeout top: Manchester frame receiver. Holds the frame FSM, the
// address/data shift registers, the address compare and the output registers.
module dusterthefirst_project
  import dusterthefirst_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int IDLE_BITS    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int HALF   = CLKS_PER_BIT / 2;
  localparam int MCLK_W = $clog2(HALF);
  localparam logic [MCLK_W-1:0] MCLK_LOAD = MCLK_W'(HALF - 1);
  localparam logic [MCLK_W-1:0] MCLK_ONE  = MCLK_W'(1);
  localparam logic [2:0] ADDR_LAST = 3'(ADDR_BITS - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [2:0]             r_bit_cnt;
  logic [2:0]             w_bit_cnt_nxt;
  logic [ADDR_BITS-1:0]   r_addr_sr;
  logic [ADDR_BITS-1:0]   w_addr_sr_nxt;
  logic [DATA_BITS-2:0]   r_data_sr;
  logic [DATA_BITS-2:0]   w_data_sr_nxt;
  logic                   w_begin;
  logic                   w_accept;

  logic [DATA_BITS-1:0]   r_parallel;
  logic                   r_valid;
  logic                   r_tb;
  logic                   r_pos;
  logic                   r_neg;
  logic                   r_mdata;
  logic                   r_mclk;
  logic [MCLK_W-1:0]      r_mclk_cnt;

  logic                   w_halt;
  logic                   w_pos;
  logic                   w_neg;
  logic                   w_strobe;
  logic                   w_bit;
  logic                   w_timeout;
  logic                   w_unused;

  assign w_unused = &{ena, uio_in, ui_in[3], ui_in[1], 1'b0};

  manchester_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .IDLE_BITS   (IDLE_BITS)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_line      (ui_in[0]),
    .i_halt      (ui_in[2]),
    .i_idle      (r_state == IDLE),
    .i_clear     (w_begin),
    .o_halt      (w_halt),
    .o_pos_edge  (w_pos),
    .o_neg_edge  (w_neg),
    .o_bit_strobe(w_strobe),
    .o_bit_val   (w_bit),
    .o_timeout   (w_timeout)
  );

  // Frame FSM next-state and shift logic; strobe and timeout are already halt-gated.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_addr_sr_nxt = r_addr_sr;
    w_data_sr_nxt = r_data_sr;
    w_begin       = 1'b0;
    w_accept      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pos && !w_halt) begin
          w_begin       = 1'b1;
          w_bit_cnt_nxt = 3'd0;
          w_state_nxt   = ADDR;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ADDR: begin
        if (w_timeout) begin
          w_state_nxt = IDLE;
        end else if (w_strobe) begin
          w_addr_sr_nxt = {r_addr_sr[ADDR_BITS-2:0], w_bit};
          if (r_bit_cnt == ADDR_LAST) begin
            w_bit_cnt_nxt = 3'd0;
            w_state_nxt   = DATA;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end else begin
          w_state_nxt = ADDR;
        end
      end
      DATA: begin
        if (w_timeout) begin
          w_state_nxt = IDLE;
        end else if (w_strobe) begin
          w_data_sr_nxt = {r_data_sr[DATA_BITS-3:0], w_bit};
          if (r_bit_cnt == DATA_LAST) begin
            w_bit_cnt_nxt = 3'd0;
            w_state_nxt   = IDLE;
            w_accept      = addr_match(r_addr_sr, ui_in[7:4]);
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Frame FSM state and shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= 3'd0;
      r_addr_sr <= '0;
      r_data_sr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_addr_sr <= w_addr_sr_nxt;
      r_data_sr <= w_data_sr_nxt;
    end
  end

  // Accepted byte and valid flag; valid clears at each frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parallel <= 8'h00;
      r_valid    <= 1'b0;
    end else begin
      if (w_begin) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
      end
      if (w_accept) begin
        r_parallel <= {r_data_sr, w_bit};
      end
    end
  end

  // Debug strobes: edge pulses, frame start and recovered clock/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tb       <= 1'b0;
      r_pos      <= 1'b0;
      r_neg      <= 1'b0;
      r_mdata    <= 1'b0;
      r_mclk     <= 1'b0;
      r_mclk_cnt <= '0;
    end else begin
      r_tb  <= w_begin;
      r_pos <= w_pos;
      r_neg <= w_neg;
      if (w_strobe) begin
        r_mdata <= w_bit;
      end
      if (w_strobe) begin
        r_mclk_cnt <= MCLK_LOAD;
      end else if (r_mclk_cnt != '0) begin
        r_mclk_cnt <= r_mclk_cnt - MCLK_ONE;
      end
      r_mclk <= w_strobe | ((r_mclk_cnt != '0) & ~w_halt);
    end
  end

  assign uo_out  = r_parallel;
  assign uio_out = {2'b00, r_pos, r_neg, r_tb, r_mdata, r_mclk, r_valid};
  assign uio_oe  = 8'b0011_1111;

endmodule

// File: tb/tb_dusterthefirst_project.sv
// Scoreboard bench for the Manchester frame receiver.
module tb_dusterthefirst_project;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  int tb_rises = 0;
  int tb_high  = 0;
  int pos_high = 0;
  int neg_high = 0;
  logic prev_valid = 1'b0;
  logic prev_tb    = 1'b0;

  dusterthefirst_project dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each rising valid and tracks debug pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (uio_out[0] && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_accept actual=0x%0h expected=none", uo_out);
        end else begin
          check("accept_byte", {24'd0, uo_out}, {24'd0, exp_q.pop_front()});
        end
      end
      if (uio_out[3] && !prev_tb) tb_rises++;
      if (uio_out[3]) tb_high++;
      if (uio_out[5]) pos_high++;
      if (uio_out[4]) neg_high++;
      prev_valid <= uio_out[0];
      prev_tb    <= uio_out[3];
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One Manchester bit: a 1 is low then high, a 0 is high then low.
  task automatic send_bit(input logic b);
    ui_in[0] = ~b;
    hold(8);
    ui_in[0] = b;
    hold(8);
  endtask

  task automatic send_frame(input logic [3:0] fa, input logic [7:0] d, input int nbits);
    logic [11:0] word;
    word = {fa, d};
    send_bit(1'b1);
    for (int i = 0; i < nbits; i++) send_bit(word[11-i]);
    ui_in[0] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    check("scoreboard_drain", exp_q.size(), 0);
  endtask

  initial begin
    int tb_r0;
    int tb_h0;
    int p0;
    int n0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    hold(3);
    check("reset_uo_out", {24'd0, uo_out}, 32'h00);
    check("reset_uio_out", {24'd0, uio_out}, 32'h00);
    rst_n = 1'b1;
    hold(40);
    check("idle_uo_out", {24'd0, uo_out}, 32'h00);
    check("idle_uio_out", {24'd0, uio_out}, 32'h00);
    check("uio_oe", {24'd0, uio_oe}, 32'h3F);

    // Addressed frame to node 3.
    ui_in[7:4] = 4'h3;
    tb_r0 = tb_rises;
    tb_h0 = tb_high;
    exp_q.push_back(8'hA5);
    send_frame(4'h3, 8'hA5, 12);
    hold(30);
    wait_drain();
    check("begin_pulses_f1", tb_rises - tb_r0, 1);
    check("begin_width_f1", tb_high - tb_h0, 1);
    check("valid_f1", {31'd0, uio_out[0]}, 1);
    check("uo_f1", {24'd0, uo_out}, 32'hA5);

    // Frame for another node: valid drops, byte retained.
    tb_r0 = tb_rises;
    send_frame(4'h5, 8'h3C, 12);
    hold(30);
    check("begin_pulses_f2", tb_rises - tb_r0, 1);
    check("valid_f2", {31'd0, uio_out[0]}, 0);
    check("uo_f2", {24'd0, uo_out}, 32'hA5);

    // Broadcast frame.
    exp_q.push_back(8'h81);
    send_frame(4'hF, 8'h81, 12);
    hold(30);
    wait_drain();
    check("valid_f3", {31'd0, uio_out[0]}, 1);
    check("uo_f3", {24'd0, uo_out}, 32'h81);

    // Truncated frame: start + 6 bits, then idle until timeout.
    tb_r0 = tb_rises;
    send_frame(4'h3, 8'hB0, 6);
    hold(40);
    check("begin_pulses_trunc", tb_rises - tb_r0, 1);
    check("valid_trunc", {31'd0, uio_out[0]}, 0);
    check("uo_trunc", {24'd0, uo_out}, 32'h81);
    tb_r0 = tb_rises;
    exp_q.push_back(8'h5A);
    send_frame(4'h3, 8'h5A, 12);
    hold(30);
    wait_drain();
    check("begin_pulses_after_timeout", tb_rises - tb_r0, 1);
    check("valid_f4", {31'd0, uio_out[0]}, 1);

    // Single rising then falling edge on the line.
    p0 = pos_high;
    n0 = neg_high;
    ui_in[0] = 1'b1;
    hold(20);
    ui_in[0] = 1'b0;
    hold(60);
    check("pos_edge_width", pos_high - p0, 1);
    check("neg_edge_width", neg_high - n0, 1);

    // Halt raised just after the start bit of a frame for this node.
    send_bit(1'b1);
    ui_in[2] = 1'b1;
    for (int i = 0; i < 12; i++) send_bit(((12'h3A5 >> (11 - i)) & 12'h001) != 12'h000);
    ui_in[0] = 1'b0;
    hold(20);
    ui_in[2] = 1'b0;
    hold(60);
    check("valid_halt", {31'd0, uio_out[0]}, 0);
    check("uo_halt", {24'd0, uo_out}, 32'h5A);
    check("scoreboard_empty_end", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
